// File: rtl/ram_dp.sv
// Dual-port RAM: port A read/write, port B read-only with valid flag, 1-cycle registered reads.
// Latency: 1 cycle on both ports; rdw_mode selects old (0) or new (1) data on write/read collisions.
// Backpressure: none; requests are ignored while busy (rst or CLEAR sweep). Optional sweep via RAM_DP_CLEAR_EN.
module ram_dp #(
  parameter int addr_width = 8,
  parameter int data_width = 8,
  parameter int rdw_mode   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_a,
  input  logic [addr_width-1:0] addr_a,
  input  logic [data_width-1:0] din_a,
  output logic [data_width-1:0] dout_a,
  input  logic                  re_b,
  input  logic [addr_width-1:0] addr_b,
  output logic [data_width-1:0] dout_b,
  output logic                  valid_b,
  output logic                  busy
);

  localparam int DEPTH = 1 << addr_width;

  logic [data_width-1:0] r_mem [DEPTH];
  logic [data_width-1:0] r_dout_a;
  logic [data_width-1:0] r_dout_b;
  logic                  r_valid_b;

  logic                  w_run;       // normal operation this cycle
  logic                  w_clr_wr;    // sweep writes zero this cycle
  logic [addr_width-1:0] w_clr_addr;  // sweep target address
  logic                  w_wr_a;      // accepted port A write
  logic                  w_coll;      // port A write hits the port B read address

`ifdef RAM_DP_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                r_state;
  logic [addr_width-1:0] r_clr_cnt;

  // Sweep FSM: zero one word per cycle, leave CLEAR after the last address (no wrap rewrite)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      if (r_clr_cnt == {addr_width{1'b1}}) begin
        r_state   <= S_RUN;
        r_clr_cnt <= '0;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  assign w_run      = !rst && (r_state == S_RUN);
  assign w_clr_wr   = !rst && (r_state == S_CLEAR);
  assign w_clr_addr = r_clr_cnt;
  assign busy       = rst || (r_state == S_CLEAR);
`else
  assign w_run      = !rst;
  assign w_clr_wr   = 1'b0;
  assign w_clr_addr = '0;
  assign busy       = 1'b0;
`endif

  assign w_wr_a = w_run && we_a;
  assign w_coll = w_wr_a && re_b && (addr_a == addr_b);

  // Storage: sweep writes take priority; user writes only in normal operation
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_a) begin
      r_mem[addr_a] <= din_a;
    end
  end

  // Registered read ports; outputs forced to zero while reset or sweeping
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_dout_a  <= '0;
      r_dout_b  <= '0;
      r_valid_b <= 1'b0;
    end else begin
      if (w_wr_a && (rdw_mode != 0)) begin
        r_dout_a <= din_a;
      end else begin
        r_dout_a <= r_mem[addr_a];
      end
      r_valid_b <= re_b;
      if (re_b) begin
        if (w_coll && (rdw_mode != 0)) begin
          r_dout_b <= din_a;
        end else begin
          r_dout_b <= r_mem[addr_b];
        end
      end
    end
  end

  assign dout_a  = r_dout_a;
  assign dout_b  = r_dout_b;
  assign valid_b = r_valid_b;

endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp (addr_width=4, data_width=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Covers the CLEAR sweep when RAM_DP_CLEAR_EN is defined, else reset-preserves-memory.
module tb_ram_dp;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int RDW = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a;
  logic [DW-1:0] dout_a;
  logic          re_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] dout_b;
  logic          valid_b;
  logic          busy;

  int n_err = 0;
  int n_chk = 0;

  ram_dp #(.addr_width(AW), .data_width(DW), .rdw_mode(RDW)) dut (
    .clk(clk), .rst(rst), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a), .re_b(re_b), .addr_b(addr_b), .dout_b(dout_b),
    .valid_b(valid_b), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] aa;
    logic [DW-1:0] d;
    logic          re;
    logic [AW-1:0] ab;
    logic          ca;
    logic [DW-1:0] ea;
    logic          cb;
    logic [DW-1:0] eb;
    logic          ev;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] aa, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ab);
    we_a   = we;
    addr_a = aa;
    din_a  = d;
    re_b   = re;
    addr_b = ab;
  endtask

  // Issue a read on both ports to addr, check both results one cycle later.
  task automatic read_both(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    drive(1'b0, addr, 8'h00, 1'b1, addr);
    step();
    chk({name, "_dout_b"}, 32'(dout_b), 32'(exp));
    chk({name, "_valid_b"}, 32'(valid_b), 32'd1);
    chk({name, "_dout_a"}, 32'(dout_a), 32'(exp));
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
  endtask

  // Count cycles until busy drops; outputs must stay quiet the whole time.
  task automatic busy_len(input string name);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
      chk({name, "_quiet_valid"}, 32'(valid_b), 32'd0);
      chk({name, "_quiet_douts"}, {16'd0, dout_a, dout_b}, 32'd0);
    end
    chk({name, "_busy_cycles"}, 32'(cnt), 32'd16);
  endtask

  initial begin
    // Table of RUN-mode vectors: inputs, then expected outputs after the edge.
    tbl[0]  = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 4'd5, 8'h11, 1'b1, 4'd3, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1};
    tbl[2]  = '{1'b0, 4'd5, 8'h00, 1'b0, 4'd0, 1'b1, 8'h11, 1'b1, 8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 4'd3, 8'h00, 1'b0, 4'd0, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[4]  = '{1'b1, 4'd5, 8'h22, 1'b1, 4'd5, 1'b1, (RDW != 0) ? 8'h22 : 8'h11,
                1'b1, (RDW != 0) ? 8'h22 : 8'h11, 1'b1};
    tbl[5]  = '{1'b0, 4'd5, 8'h00, 1'b1, 4'd5, 1'b1, 8'h22, 1'b1, 8'h22, 1'b1};
    tbl[6]  = '{1'b1, 4'd3, 8'h77, 1'b1, 4'd5, 1'b1, (RDW != 0) ? 8'h77 : 8'hA5,
                1'b1, 8'h22, 1'b1};
    tbl[7]  = '{1'b0, 4'd3, 8'h00, 1'b0, 4'd0, 1'b1, 8'h77, 1'b1, 8'h22, 1'b0};
    tbl[8]  = '{1'b0, 4'd5, 8'h00, 1'b1, 4'd3, 1'b1, 8'h22, 1'b1, 8'h77, 1'b1};
    tbl[9]  = '{1'b0, 4'd5, 8'h00, 1'b1, 4'd5, 1'b1, 8'h22, 1'b1, 8'h22, 1'b1};
    tbl[10] = '{1'b1, 4'd0, 8'hFF, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0};
    tbl[11] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1};

    // Reset state
    rst = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    step();
    step();
    chk("rst_douts", {16'd0, dout_a, dout_b}, 32'd0);
    chk("rst_valid_b", 32'(valid_b), 32'd0);
`ifdef RAM_DP_CLEAR_EN
    chk("rst_busy", 32'(busy), 32'd1);

    // Initial sweep with write and read requests that must be ignored
    drive(1'b1, 4'd2, 8'hFF, 1'b1, 4'd2);
    rst = 1'b0;
    #1;
    busy_len("sweep0");
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    // First request right after busy falls is accepted; write during busy was dropped
    read_both(4'd2, 8'h00, "busy_wr_addr2");
    for (int i = 0; i < 16; i++) read_both(i[AW-1:0], 8'h00, $sformatf("sweep0_rd%0d", i));

    // Fill memory, then reset in the middle of a sweep
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i[AW-1:0], 8'(i + 1), 1'b0, 4'd0);
      step();
    end
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("midclr_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("midclr_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    busy_len("sweep1");
    for (int i = 0; i < 16; i++) read_both(i[AW-1:0], 8'h00, $sformatf("sweep1_rd%0d", i));
`else
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    drive(1'b1, 4'd9, 8'h3C, 1'b0, 4'd0);
    step();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    rst = 1'b1;
    step();
    chk("noclr_rst_busy", 32'(busy), 32'd0);
    chk("noclr_rst_douts", {16'd0, dout_a, dout_b}, 32'd0);
    rst = 1'b0;
    #1;
    chk("noclr_busy", 32'(busy), 32'd0);
    read_both(4'd9, 8'h3C, "noclr_keep9");
`endif

    // Table-driven RUN vectors
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we, tbl[i].aa, tbl[i].d, tbl[i].re, tbl[i].ab);
      step();
      if (tbl[i].ca) chk($sformatf("vec%0d_dout_a", i), 32'(dout_a), 32'(tbl[i].ea));
      if (tbl[i].cb) chk($sformatf("vec%0d_dout_b", i), 32'(dout_b), 32'(tbl[i].eb));
      chk($sformatf("vec%0d_valid_b", i), 32'(valid_b), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
    end

    // Reset during RUN abandons an in-flight read
    drive(1'b0, 4'd3, 8'h00, 1'b1, 4'd3);
    rst = 1'b1;
    step();
    chk("runrst_valid_b", 32'(valid_b), 32'd0);
    chk("runrst_douts", {16'd0, dout_a, dout_b}, 32'd0);
    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    rst = 1'b0;
    #1;
`ifdef RAM_DP_CLEAR_EN
    busy_len("sweep2");
    read_both(4'd3, 8'h00, "runrst_rd3");
`else
    chk("runrst_busy", 32'(busy), 32'd0);
    read_both(4'd3, 8'h77, "runrst_rd3");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL have parameter addr_width, default 8: address width; depth is 2^addr_width words.
REQ-002 SHALL have parameter data_width, default 8: word width in bits.
REQ-003 SHALL have parameter rdw_mode, default 0: read-during-write behaviour, 0 = old data, 1 = new data.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port we_a, input, 1: port A write enable.
REQ-007 SHALL have port addr_a, input, addr_width: port A address.
REQ-008 SHALL have port din_a, input, data_width: port A write data.
REQ-009 SHALL have port dout_a, output, data_width: port A registered read data.
REQ-010 SHALL have port re_b, input, 1: port B read request.
REQ-011 SHALL have port addr_b, input, addr_width: port B read address.
REQ-012 SHALL have port dout_b, output, data_width: port B registered read data.
REQ-013 SHALL have port valid_b, output, 1: dout_b carries data for a request accepted the previous cycle.
REQ-014 SHALL have port busy, output, 1: memory is clearing, and all requests are ignored.

Function
REQ-015 SHALL implement two states: CLEAR (busy=1) and RUN (busy=0).
REQ-016 In RUN, when we_a=1, SHALL write din_a to mem[addr_a] at the clock edge.
REQ-017 In RUN, every cycle, SHALL load dout_a with mem[addr_a]; latency is 1 cycle.
REQ-018 In RUN with re_b=1, SHALL load dout_b with mem[addr_b] and assert valid_b for exactly the next cycle.
REQ-019 In RUN with re_b=0, SHALL hold dout_b and drive valid_b=0 the next cycle.
REQ-020 On a same-cycle port A write and port B read to the same address, SHALL load dout_b with the old word if rdw_mode=0, or with din_a if rdw_mode=1.
REQ-021 On a port A write, SHALL apply the rdw_mode rule of REQ-020 to dout_a.
REQ-022 In CLEAR, SHALL write zero to mem[clr_cnt] each cycle, with clr_cnt counting 0 to 2^addr_width-1.
REQ-023 After writing the last address, SHALL move from CLEAR to RUN, so busy is high for exactly 2^addr_width cycles after rst deasserts.
REQ-024 In CLEAR, SHALL ignore we_a and re_b, hold dout_a=0 and dout_b=0, and drive valid_b=0.
REQ-025 At the clr_cnt wrap point, SHALL not write any address twice.
REQ-026 SHALL accept the first request in the cycle after busy falls.

Reset
REQ-027 While rst=1, SHALL drive dout_a=0, dout_b=0 and valid_b=0, reset clr_cnt to 0, and enter CLEAR (or RUN per REQ-031).
REQ-028 If rst asserts during CLEAR, SHALL restart the sweep from address 0 after rst deasserts.
REQ-029 If rst asserts during RUN, SHALL abandon any in-flight read, so that valid_b=0 in the next cycle.

Configuration
REQ-030 With macro RAM_DP_CLEAR_EN defined, SHALL implement the CLEAR sweep of REQ-022 to REQ-028, and busy=1 while rst=1.
REQ-031 Without RAM_DP_CLEAR_EN, SHALL omit the CLEAR state and the clr_cnt counter, tie busy to 0, leave memory contents unchanged by reset, and enter RUN directly after rst.

Verification (addr_width=4, data_width=8)
REQ-032 Clear sweep: with RAM_DP_CLEAR_EN, pulse rst for 1 cycle -> busy=1 for exactly 16 cycles; then re_b on addresses 0..15 -> dout_b=0x00 each time, with valid_b one cycle after each re_b.
REQ-033 Basic write/read: write 0xA5 to address 3, then re_b with addr_b=3 the next cycle -> dout_b=0xA5 and valid_b=1 one cycle later; with re_b=0 after that -> dout_b holds 0xA5 and valid_b=0.
REQ-034 Collision: with mem[5]=0x11, write 0x22 to address 5 with re_b, addr_b=5 in the same cycle -> dout_a=dout_b=0x11 if rdw_mode=0, or 0x22 if rdw_mode=1; a later read of address 5 -> 0x22.
REQ-035 Reset mid-clear: assert rst at clear cycle 7 -> busy stays 1 for 16 cycles after rst deasserts, and all addresses then read 0x00.
REQ-036 Write while busy: we_a=1, addr_a=2, din_a=0xFF during CLEAR -> after busy falls, a read of address 2 returns 0x00.
REQ-037 Clear disabled: without RAM_DP_CLEAR_EN, write 0x3C to address 9 before rst, then pulse rst -> busy=0 throughout, and the first post-reset read of address 9 returns 0x3C.
